// File: rtl/garuda_act_dma_pkg.sv
// Shared types and constants for the activation-buffer DMA fill engine.
package garuda_act_dma_pkg;

  localparam int DEF_BUF_DEPTH      = 16384;
  localparam int DEF_ADDR_WIDTH     = 14;
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_MEM_ADDR_WIDTH = 32;
  localparam int WORD_BYTES         = DEF_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    DRAIN     = 2'd2,
    WAIT_SWAP = 2'd3
  } dma_state_t;

  // Latched transfer command; widths follow the default buffer geometry.
  typedef struct packed {
    logic [DEF_MEM_ADDR_WIDTH-1:0] src;
    logic [DEF_ADDR_WIDTH-1:0]     dst;
    logic [DEF_ADDR_WIDTH:0]       len;
  } dma_cmd_t;

endpackage

// File: rtl/act_dma_credit_counter.sv
// Tracks memory reads in flight and says whether another may be issued.
// A response arriving this cycle frees a slot immediately, so a full
// window can still issue when a response lands in the same cycle.
module act_dma_credit_counter #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic can_issue_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [CNT_W-1:0] count_reg;

  // In-flight count: +1 per issued read, -1 per returned word, both = hold.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      count_reg <= '0;
    end else if (inc_i && !dec_i) begin
      count_reg <= count_reg + CNT_W'(1);
    end else if (dec_i && !inc_i && (count_reg != '0)) begin
      count_reg <= count_reg - CNT_W'(1);
    end
  end

  assign can_issue_o = (count_reg < CNT_W'(MAX_OUTSTANDING)) || dec_i;

endmodule

// File: rtl/activation_dma_writer.sv
// Fill engine for the ping-pong activation buffer: reads words from memory
// and writes them into the bank being filled, then swaps banks once the
// consumer has released the other one.
module activation_dma_writer
  import garuda_act_dma_pkg::*;
#(
  parameter int BUF_DEPTH       = DEF_BUF_DEPTH,
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int MEM_ADDR_WIDTH  = DEF_MEM_ADDR_WIDTH,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [MEM_ADDR_WIDTH-1:0] cmd_src_addr_i,
  input  logic [ADDR_WIDTH-1:0]     cmd_dst_addr_i,
  input  logic [ADDR_WIDTH:0]       cmd_len_i,
  output logic                      mem_req_valid_o,
  input  logic                      mem_req_ready_i,
  output logic [MEM_ADDR_WIDTH-1:0] mem_req_addr_o,
  input  logic                      mem_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0]     mem_rsp_data_i,
  output logic                      buf_wr_en_o,
  output logic [ADDR_WIDTH-1:0]     buf_wr_addr_o,
  output logic [DATA_WIDTH-1:0]     buf_wr_data_o,
  input  logic                      buf_wr_ready_i,
  output logic                      ping_pong_sel_o,
  input  logic                      consumer_release_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      error_o
);

  dma_state_t              state_reg;
  dma_cmd_t                cmd_reg;
  logic [ADDR_WIDTH:0]     req_cnt_reg;
  logic [ADDR_WIDTH:0]     rsp_cnt_reg;
  logic [ADDR_WIDTH:0]     ack_cnt_reg;
  logic [ADDR_WIDTH:0]     ack_cnt_next;
  logic                    release_reg;
  logic                    sel_reg;
  logic                    done_reg;
  logic                    error_reg;
  logic                    wr_en_reg;
  logic [ADDR_WIDTH-1:0]   wr_addr_reg;
  logic [DATA_WIDTH-1:0]   wr_data_reg;

  logic                    fill_active;
  logic                    cmd_legal;
  logic                    cmd_accept;
  logic                    req_fire;
  logic                    rsp_take;
  logic                    ack_inc;
  logic                    can_issue;
  logic [ADDR_WIDTH+1:0]   cmd_end;

  // Extra two bits keep dst+len from wrapping before the range check.
  assign cmd_end    = (ADDR_WIDTH+2)'(cmd_dst_addr_i) + (ADDR_WIDTH+2)'(cmd_len_i);
  assign cmd_legal  = (cmd_len_i != '0) && (cmd_end <= (ADDR_WIDTH+2)'(BUF_DEPTH));
  assign cmd_ready_o = (state_reg == IDLE);
  assign cmd_accept = cmd_valid_i && cmd_ready_o && cmd_legal;

  // Responses and acks only count while a fill is in progress; stray
  // traffic after a reset or between commands is dropped here.
  assign fill_active = (state_reg == REQ) || (state_reg == DRAIN);
  assign rsp_take    = mem_rsp_valid_i && fill_active;
  assign ack_inc     = buf_wr_ready_i && (state_reg != IDLE) && (ack_cnt_reg < cmd_reg.len);
  assign ack_cnt_next = ack_inc ? ack_cnt_reg + (ADDR_WIDTH+1)'(1) : ack_cnt_reg;

  assign mem_req_valid_o = (state_reg == REQ) && (req_cnt_reg < cmd_reg.len) && can_issue;
  assign mem_req_addr_o  = cmd_reg.src + (MEM_ADDR_WIDTH'(req_cnt_reg) * MEM_ADDR_WIDTH'(WORD_BYTES));
  assign req_fire        = mem_req_valid_o && mem_req_ready_i;

  act_dma_credit_counter #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_credit (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (cmd_accept),
    .inc_i       (req_fire),
    .dec_i       (rsp_take),
    .can_issue_o (can_issue)
  );

  // Control FSM: command intake, request/ack counting, release and bank swap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      cmd_reg     <= '0;
      req_cnt_reg <= '0;
      ack_cnt_reg <= '0;
      release_reg <= 1'b0;
      sel_reg     <= 1'b0;
      done_reg    <= 1'b0;
      error_reg   <= 1'b0;
    end else begin
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
      if (consumer_release_i) release_reg <= 1'b1;
      if (req_fire)           req_cnt_reg <= req_cnt_reg + (ADDR_WIDTH+1)'(1);
      if (ack_inc)            ack_cnt_reg <= ack_cnt_next;
      case (state_reg)
        IDLE: begin
          if (cmd_valid_i) begin
            if (cmd_legal) begin
              cmd_reg     <= '{src: cmd_src_addr_i, dst: cmd_dst_addr_i, len: cmd_len_i};
              req_cnt_reg <= '0;
              ack_cnt_reg <= '0;
              state_reg   <= REQ;
            end else begin
              error_reg <= 1'b1;
            end
          end
        end
        REQ: begin
          if (req_cnt_reg == cmd_reg.len) state_reg <= DRAIN;
        end
        DRAIN: begin
          // Looking at the next ack count saves a cycle on the last ack.
          if (ack_cnt_next == cmd_reg.len) state_reg <= WAIT_SWAP;
        end
        WAIT_SWAP: begin
          if (release_reg || consumer_release_i) begin
            state_reg   <= IDLE;
            sel_reg     <= ~sel_reg;
            done_reg    <= 1'b1;
            release_reg <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Write path: each accepted response becomes one registered buffer write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_cnt_reg <= '0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      wr_en_reg <= 1'b0;
      if (cmd_accept) begin
        rsp_cnt_reg <= '0;
      end else if (rsp_take) begin
        wr_en_reg   <= 1'b1;
        wr_addr_reg <= cmd_reg.dst + rsp_cnt_reg[ADDR_WIDTH-1:0];
        wr_data_reg <= mem_rsp_data_i;
        rsp_cnt_reg <= rsp_cnt_reg + (ADDR_WIDTH+1)'(1);
      end
    end
  end

  assign buf_wr_en_o     = wr_en_reg;
  assign buf_wr_addr_o   = wr_addr_reg;
  assign buf_wr_data_o   = wr_data_reg;
  assign ping_pong_sel_o = sel_reg;
  assign busy_o          = (state_reg != IDLE);
  assign done_o          = done_reg;
  assign error_o         = error_reg;

endmodule

// File: tb/tb_activation_dma_writer.sv
// Bench for activation_dma_writer: memory/buffer models with a scoreboard,
// a table of commands, and hand sequences for latency, swap gating and reset.
module tb_activation_dma_writer;

  localparam int MAXO = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [31:0] cmd_src_addr_i;
  logic [13:0] cmd_dst_addr_i;
  logic [14:0] cmd_len_i;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [31:0] mem_req_addr_o;
  logic        mem_rsp_valid_i;
  logic [31:0] mem_rsp_data_i;
  logic        buf_wr_en_o;
  logic [13:0] buf_wr_addr_o;
  logic [31:0] buf_wr_data_o;
  logic        buf_wr_ready_i;
  logic        ping_pong_sel_o;
  logic        consumer_release_i;
  logic        busy_o;
  logic        done_o;
  logic        error_o;

  activation_dma_writer #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .cmd_valid_i        (cmd_valid_i),
    .cmd_ready_o        (cmd_ready_o),
    .cmd_src_addr_i     (cmd_src_addr_i),
    .cmd_dst_addr_i     (cmd_dst_addr_i),
    .cmd_len_i          (cmd_len_i),
    .mem_req_valid_o    (mem_req_valid_o),
    .mem_req_ready_i    (mem_req_ready_i),
    .mem_req_addr_o     (mem_req_addr_o),
    .mem_rsp_valid_i    (mem_rsp_valid_i),
    .mem_rsp_data_i     (mem_rsp_data_i),
    .buf_wr_en_o        (buf_wr_en_o),
    .buf_wr_addr_o      (buf_wr_addr_o),
    .buf_wr_data_o      (buf_wr_data_o),
    .buf_wr_ready_i     (buf_wr_ready_i),
    .ping_pong_sel_o    (ping_pong_sel_o),
    .consumer_release_i (consumer_release_i),
    .busy_o             (busy_o),
    .done_o             (done_o),
    .error_o            (error_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // ---------------- memory / buffer models and scoreboard ----------------
  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic [13:0] a; logic [31:0] d; } wr_t;

  pend_t       pend_q[$];
  logic [31:0] exp_req_q[$];
  wr_t         exp_wr_q[$];
  int          cyc = 0;
  int          mem_lat = 1;
  bit          rand_ready = 0;
  int          out_cnt = 0;
  int          max_out = 0;
  int          fire_cnt = 0;
  int          wr_cnt = 0;
  bit          wr_seen = 0;
  bit          stalled = 0;
  logic [31:0] hold_addr = '0;

  always begin
    @(posedge clk_i);
    #1;
    cyc++;
    mem_req_ready_i = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    buf_wr_ready_i  = wr_seen;
    if (!rst_i && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      pend_t p;
      p = pend_q.pop_front();
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = mem_data(p.addr);
    end else begin
      mem_rsp_valid_i = 1'b0;
      mem_rsp_data_i  = '0;
    end
    @(negedge clk_i);
    wr_seen = buf_wr_en_o;
    if (rst_i) begin
      stalled = 0;
      out_cnt = 0;
    end else begin
      if (stalled) begin
        check("req_hold_valid", mem_req_valid_o, 1'b1);
        check("req_hold_addr", mem_req_addr_o, hold_addr);
      end
      stalled   = mem_req_valid_o && !mem_req_ready_i;
      hold_addr = mem_req_addr_o;
      if (mem_req_valid_o && mem_req_ready_i) begin
        fire_cnt++;
        out_cnt++;
        pend_q.push_back('{addr: mem_req_addr_o, due: cyc + mem_lat});
        if (exp_req_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_req: got addr %0h required no request", mem_req_addr_o);
        end else begin
          check("req_addr", mem_req_addr_o, exp_req_q.pop_front());
        end
      end
      if (mem_rsp_valid_i && out_cnt > 0) out_cnt--;
      if (out_cnt > max_out) max_out = out_cnt;
      if (buf_wr_en_o) begin
        wr_cnt++;
        if (exp_wr_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_write: got addr %0h data %0h required no write", buf_wr_addr_o, buf_wr_data_o);
        end else begin
          wr_t w;
          w = exp_wr_q.pop_front();
          check("wr_addr", buf_wr_addr_o, w.a);
          check("wr_data", buf_wr_data_o, w.d);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_expect(input logic [31:0] src, input logic [13:0] dst, input int len);
    for (int i = 0; i < len; i++) begin
      logic [31:0] a;
      a = src + 32'(i * 4);
      exp_req_q.push_back(a);
      exp_wr_q.push_back('{a: dst + 14'(i), d: mem_data(a)});
    end
  endtask

  task automatic send_cmd(input logic [31:0] src, input logic [13:0] dst, input logic [14:0] len);
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b1; cmd_src_addr_i = src; cmd_dst_addr_i = dst; cmd_len_i = len;
    @(negedge clk_i);
    check("cmd_ready_at_issue", cmd_ready_o, 1'b1);
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic pulse_release();
    @(posedge clk_i); #1; consumer_release_i = 1'b1;
    @(posedge clk_i); #1; consumer_release_i = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit seen);
    seen = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk_i);
      if (done_o) begin seen = 1; break; end
    end
  endtask

  typedef struct {
    logic [31:0] src; logic [13:0] dst; logic [14:0] len;
    int lat; bit rnd; bit exp_err; bit full;
  } vec_t;

  vec_t vecs[7];
  logic exp_sel = 1'b0;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int f0, w0;
    rst_i = 1'b1; cmd_valid_i = 0; cmd_src_addr_i = '0; cmd_dst_addr_i = '0; cmd_len_i = '0;
    mem_req_ready_i = 1; mem_rsp_valid_i = 0; mem_rsp_data_i = '0;
    buf_wr_ready_i = 0; consumer_release_i = 0;

    vecs[0] = '{32'h0000_1000, 14'd0,     15'd4,     1, 0, 0, 0};  // basic fill
    vecs[1] = '{32'h0000_2000, 14'd100,   15'd8,     6, 0, 0, 1};  // credit limit
    vecs[2] = '{32'h0000_3000, 14'd16380, 15'd8,     1, 0, 1, 0};  // overruns bank
    vecs[3] = '{32'h0000_3000, 14'd0,     15'd0,     1, 0, 1, 0};  // zero length
    vecs[4] = '{32'hFFFF_FFF8, 14'd16380, 15'd4,     2, 1, 0, 0};  // wrap, backpressure, ends at depth
    vecs[5] = '{32'h0000_0040, 14'd16383, 15'd1,     4, 0, 0, 0};  // last word only
    vecs[6] = '{32'h0000_0000, 14'd1,     15'd16384, 1, 0, 1, 0};  // one past depth

    // Reset values
    repeat (3) @(negedge clk_i);
    check("rst_cmd_ready", cmd_ready_o, 1'b1);
    check("rst_busy", busy_o, 1'b0);
    check("rst_req_valid", mem_req_valid_o, 1'b0);
    check("rst_wr_en", buf_wr_en_o, 1'b0);
    check("rst_sel", ping_pong_sel_o, 1'b0);
    check("rst_done_err", {done_o, error_o}, 2'b00);
    @(posedge clk_i); #1; rst_i = 1'b0;

    // Table-driven commands
    foreach (vecs[k]) begin
      mem_lat = vecs[k].lat; rand_ready = vecs[k].rnd; max_out = 0; f0 = fire_cnt;
      if (!vecs[k].exp_err) begin
        pulse_release();
        push_expect(vecs[k].src, vecs[k].dst, int'(vecs[k].len));
      end
      send_cmd(vecs[k].src, vecs[k].dst, vecs[k].len);
      if (vecs[k].exp_err) begin
        @(negedge clk_i);
        check("error_pulse", error_o, 1'b1);
        check("illegal_stays_idle", {busy_o, cmd_ready_o}, 2'b01);
        @(negedge clk_i);
        check("error_one_cycle", error_o, 1'b0);
        repeat (4) @(negedge clk_i);
        check("illegal_no_requests", fire_cnt, f0);
        $display("vec %0d: dst=%0d len=%0d rejected", k, vecs[k].dst, vecs[k].len);
      end else begin
        wait_done(3000, seen);
        check("done_seen", seen, 1'b1);
        exp_sel = ~exp_sel;
        check("sel_toggle", ping_pong_sel_o, exp_sel);
        check("ready_after_swap", cmd_ready_o, 1'b1);
        @(negedge clk_i);
        check("done_one_cycle", done_o, 1'b0);
        check("all_reqs_issued", exp_req_q.size(), 0);
        check("all_words_written", exp_wr_q.size(), 0);
        check("outstanding_le_max", (max_out <= MAXO), 1'b1);
        if (vecs[k].full) check("outstanding_reaches_max", max_out, MAXO);
        $display("vec %0d: src=%0h dst=%0d len=%0d max_outstanding=%0d sel=%0d",
                 k, vecs[k].src, vecs[k].dst, vecs[k].len, max_out, ping_pong_sel_o);
      end
      rand_ready = 0;
    end

    // Minimum latency, len=1, release already set
    mem_lat = 1;
    pulse_release();
    push_expect(32'h0000_0300, 14'd5, 1);
    send_cmd(32'h0000_0300, 14'd5, 15'd1);
    @(negedge clk_i); check("lat_c1_req", mem_req_valid_o, 1'b1);
    @(negedge clk_i); check("lat_c2_no_wr", buf_wr_en_o, 1'b0);
    @(negedge clk_i); check("lat_c3_wr", {buf_wr_en_o, buf_wr_addr_o}, {1'b1, 14'd5});
    @(negedge clk_i); check("lat_c4_busy", busy_o, 1'b1);
    @(negedge clk_i); check("lat_c5_wait", {cmd_ready_o, done_o}, 2'b00);
    @(negedge clk_i); check("lat_c6_done", {cmd_ready_o, done_o}, 2'b11);
    exp_sel = ~exp_sel;
    check("lat_sel", ping_pong_sel_o, exp_sel);
    $display("latency: len=1 done at cycle 6 sel=%0d", ping_pong_sel_o);

    // Swap gating: fill completes without release
    mem_lat = 2;
    push_expect(32'h0000_0500, 14'd20, 2);
    send_cmd(32'h0000_0500, 14'd20, 15'd2);
    seen = 0;
    repeat (30) begin @(negedge clk_i); if (done_o) seen = 1; end
    check("gate_no_done", seen, 1'b0);
    check("gate_holding", {busy_o, cmd_ready_o}, 2'b10);
    check("gate_words_written", exp_wr_q.size(), 0);
    @(posedge clk_i); #1; consumer_release_i = 1'b1;
    @(negedge clk_i);
    check("gate_release_cycle_sel", ping_pong_sel_o, exp_sel);
    @(posedge clk_i); #1; consumer_release_i = 1'b0;
    @(negedge clk_i);
    exp_sel = ~exp_sel;
    check("gate_swap", {done_o, ping_pong_sel_o, cmd_ready_o}, {1'b1, exp_sel, 1'b1});
    $display("swap gating: released after 30 cycles sel=%0d", ping_pong_sel_o);

    // Reset after 3 of 8 words; leftover responses must be ignored
    mem_lat = 3; w0 = wr_cnt;
    push_expect(32'h0000_8000, 14'd40, 8);
    send_cmd(32'h0000_8000, 14'd40, 15'd8);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (wr_cnt - w0 >= 3) begin seen = 1; break; end
    end
    check("reset_three_words", seen, 1'b1);
    @(posedge clk_i); #1; rst_i = 1'b1;
    @(negedge clk_i);
    while (pend_q.size() > 2) begin pend_t p; p = pend_q.pop_back(); end
    exp_req_q.delete(); exp_wr_q.delete();
    exp_sel = 1'b0;
    @(posedge clk_i); #1; rst_i = 1'b0;
    w0 = wr_cnt; f0 = fire_cnt;
    repeat (10) @(negedge clk_i);
    check("reset_no_writes", wr_cnt, w0);
    check("reset_no_requests", fire_cnt, f0);
    check("reset_rsp_drained", pend_q.size(), 0);
    check("reset_ctrl", {cmd_ready_o, busy_o, done_o, error_o, ping_pong_sel_o}, 5'b10000);
    check("reset_req", {mem_req_valid_o, mem_req_addr_o}, 33'h0);
    check("reset_wr", {buf_wr_en_o, buf_wr_addr_o, buf_wr_data_o}, 47'h0);
    $display("reset mid-transfer: writes after reset=%0d sel=%0d", wr_cnt - w0, ping_pong_sel_o);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
